x7seg_mux: RTL
==============

Name: x7seg_mux

Overview:
Parametrised time-multiplexed hexadecimal seven-segment driver for DIGITS common-anode digits, with active-low segment and anode outputs. It is the successor of the fixed 4-digit x7seg driver. New features over x7seg:
- per-digit decimal point and blanking
- leading-zero suppression
- PWM brightness
- tear-free double-buffered load, committed only at frame boundaries

It sits between datapath/status registers and the board display pins.

Parameters:
DIGITS, 4, number of digits; DIGITS >= 2.
DIV_BITS, 18, refresh prescaler width; one digit slot lasts 2^DIV_BITS clk cycles.
BRIGHT_BITS, 4, brightness resolution; BRIGHT_BITS < DIV_BITS.

Ports:
clk  in  1  system clock.
clr  in  1  reset; asynchronous, active-low.
x  in  4*DIGITS  hex value; nibble i drives digit i, digit 0 rightmost.
load  in  1  one-cycle strobe; captures x, dp_in and blank into the shadow register.
dp_in  in  DIGITS  decimal point per digit, 1 = lit; captured with load.
blank  in  DIGITS  force digit i dark, 1 = dark; captured with load.
lz_en  in  1  leading-zero suppression enable; live, not captured.
bright  in  BRIGHT_BITS  duty; 0 = off, 2^BRIGHT_BITS-1 = maximum; live.
a_to_g  out  7  segments, active-low; bit6 = a ... bit0 = g.
dp  out  1  decimal point, active-low.
an  out  DIGITS  anode enables, active-low, one-hot-low or all ones.
frame_tick  out  1  one-cycle pulse when the digit index wraps to 0.

Behaviour:
Reset values (clr low, immediate and asynchronous, also mid-frame):
- a_to_g = 7'h7F, dp = 1, an = all ones, frame_tick = 0
- prescaler = 0, digit index = 0
- shadow and active registers = 0, pending = 0

Prescaler and digit index:
- Prescaler increments every clk.
- When it equals all ones, the digit index advances; DIGITS-1 wraps to 0.

Load and commit:
- load = 1 writes the shadow register and sets pending.
- On an index wrap with pending = 1: active <= shadow, pending <= 0, frame_tick pulses.
- frame_tick pulses on every wrap, regardless of pending.
- load coinciding with a commit: active takes the old shadow; shadow takes the new inputs; pending stays 1, so the new value commits on the next frame.

Display output:
- Digit i is dark if any of the following hold:
  - active blank[i] = 1
  - lz_en = 1, i > 0, and nibbles DIGITS-1 down to i of active x are all zero. Digit 0 is never suppressed.
  - PWM phase >= bright, where phase = prescaler[DIV_BITS-1 -: BRIGHT_BITS].
- Dark digit: an = all ones, a_to_g = 7'h7F, dp = 1.
- Lit digit: an[i] = 0 and all other anode bits 1; a_to_g = font(nibble i); dp = ~active dp_in[i].
- Outputs are registered: one clk of latency from prescaler/index state to pins.

Font (a..g, active-low):
0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.

Decomposition:
- Package x7seg_pkg: SEG_BLANK = 7'h7F and the 16-entry font constant.
- Sub-module hex7seg: combinational nibble-to-segment decoder using the package font, instantiated once on the selected nibble.

Test Plan:
All scenarios use DIGITS=4, DIV_BITS=4, BRIGHT_BITS=2 (16-cycle slots).
1. Reset mid-slot: drive clr low -> same-time a_to_g=7F, an=1111, dp=1, frame_tick=0; release -> digit 0 slot begins with prescaler 0.
2. Load x=16'h000A, lz_en=0, blank=0, bright=3:
   - nothing changes until frame_tick; after it, the digit 0 slot shows an=1110, a_to_g=0001000 and the digit 1 slot shows an=1101, a_to_g=0000001.
   - an is active for 12 of 16 cycles per slot.
3. Leading-zero suppression, lz_en=1:
   - x=16'h000A -> digits 3..1 dark and digit 0 shows A.
   - x=16'h0000 -> digit 0 shows 0 (0000001).
   - x=16'h0A00 -> digit 3 dark; digits 2..0 show A, 0, 0.
4. Brightness: bright=1 -> an low for exactly 4 cycles per slot; bright=0 -> an stays 1111 for a whole frame.
5. Tearing: load 16'h1234 mid-frame, then load 16'h5678 on the exact commit cycle -> next frame shows 1234, the following frame shows 5678; frame_tick is exactly 1 cycle wide every 64 cycles.
6. dp_in=4'b0100, blank=4'b0001 -> digit 2 slot dp=0; digit 0 slot an=1111, a_to_g=7F; other slots dp=1.

Source files
------------

// File: rtl/x7seg_pkg.sv
// Shared constants for the multiplexed seven-segment driver: blank pattern and hex font.
// All segment patterns are active-low, bit6 = a ... bit0 = g.
package x7seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] FONT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble-to-segment decoder, active-low segments.
module hex7seg
  import x7seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = FONT[nibble_i];

endmodule

// File: rtl/x7seg_mux.sv
// Time-multiplexed hex seven-segment driver with decimal points, blanking, leading-zero
// suppression, PWM brightness and a shadow/active register pair committed on frame wrap.
module x7seg_mux
  import x7seg_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned DIV_BITS    = 18,
  parameter int unsigned BRIGHT_BITS = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [4*DIGITS-1:0]    x,
  input  logic                   load,
  input  logic [DIGITS-1:0]      dp_in,
  input  logic [DIGITS-1:0]      blank,
  input  logic                   lz_en,
  input  logic [BRIGHT_BITS-1:0] bright,
  output logic [6:0]             a_to_g,
  output logic                   dp,
  output logic [DIGITS-1:0]      an,
  output logic                   frame_tick
);

  localparam int unsigned IdxW = $clog2(DIGITS);

  logic [DIV_BITS-1:0]    presc_q, presc_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [4*DIGITS-1:0]    sh_x_q, act_x_q;
  logic [DIGITS-1:0]      sh_dp_q, act_dp_q;
  logic [DIGITS-1:0]      sh_blank_q, act_blank_q;
  logic                   pending_q, pending_d;
  logic                   slot_end, wrap, commit;

  logic [6:0]             seg_q, seg_d;
  logic                   dp_q, dp_d;
  logic [DIGITS-1:0]      an_q, an_d;
  logic                   tick_q;

  logic [3:0]             sel_nibble;
  logic [6:0]             font_seg;
  logic [DIGITS-1:0]      lz_dark;
  logic [BRIGHT_BITS-1:0] phase;
  logic                   all_zero, dark;

  // Slot and frame timing
  always_comb begin
    slot_end = &presc_q;
    wrap     = slot_end && (idx_q == IdxW'(DIGITS - 1));
    commit   = wrap && pending_q;
    presc_d  = presc_q + DIV_BITS'(1);
    idx_d    = idx_q;
    if (slot_end) begin
      idx_d = wrap ? '0 : idx_q + IdxW'(1);
    end
    // A load on the commit cycle re-arms pending so the new value lands next frame.
    pending_d = load | (pending_q & ~wrap);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      presc_q     <= '0;
      idx_q       <= '0;
      pending_q   <= 1'b0;
      sh_x_q      <= '0;
      sh_dp_q     <= '0;
      sh_blank_q  <= '0;
      act_x_q     <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      if (load) begin
        sh_x_q     <= x;
        sh_dp_q    <= dp_in;
        sh_blank_q <= blank;
      end
      if (commit) begin
        act_x_q     <= sh_x_q;
        act_dp_q    <= sh_dp_q;
        act_blank_q <= sh_blank_q;
      end
    end
  end

  assign sel_nibble = act_x_q[4*int'(idx_q) +: 4];

  hex7seg u_hex7seg (
    .nibble_i (sel_nibble),
    .seg_o    (font_seg)
  );

  // Digit i is a leading zero when every nibble from the top down to i is zero.
  always_comb begin
    lz_dark  = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero   = all_zero & (act_x_q[4*i +: 4] == 4'h0);
      lz_dark[i] = all_zero;
    end
  end

  always_comb begin
    phase = presc_q[DIV_BITS-1 -: BRIGHT_BITS];
    dark  = act_blank_q[idx_q] | (lz_en & lz_dark[idx_q]) | (phase >= bright);
    if (dark) begin
      an_d  = '1;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end else begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = font_seg;
      dp_d  = ~act_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
      an_q   <= '1;
      tick_q <= 1'b0;
    end else begin
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
      tick_q <= wrap;
    end
  end

  assign a_to_g     = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule
